uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Parametrised UART receiver; fills the receive path beside the existing transmitter in the uart top.
- Generalises the fixed 8-bit, x16 scheme: configurable data width, oversampling factor, optional parity, 1 or 2 stop bits.
- Adds error and break reporting and a valid/ready output holding register with overrun detection.
- Driven by the shared baud-tick generator; feeds the rx FIFO and CSR error bits.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9), LSB first.
- OVERSAMPLE, 16, baud_tick_i pulses per bit period (even, >=8).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- baud_tick_i  input  1  one-cycle pulse at OVERSAMPLE x baudrate.
- rx_i  input  1  asynchronous serial line, idle high.
- rx_en_i  input  1  receiver enable.
- parity_en_i  input  1  expect parity bit after data.
- parity_odd_i  input  1  1 = odd parity, 0 = even.
- stop2_i  input  1  1 = two stop bits.
- rx_data_o  output  DATA_WIDTH  received word.
- rx_valid_o  output  1  rx_data_o and error flags valid.
- rx_ready_i  input  1  consumer accepts word.
- parity_err_o  output  1  parity mismatch for held word.
- framing_err_o  output  1  stop bit sampled low for held word.
- break_o  output  1  break condition for held word.
- overrun_o  output  1  one-cycle pulse: completed frame dropped.
- busy_o  output  1  high in any state except IDLE.

Behaviour:
- Reset: all outputs 0; rx_data_o = 0; FSM in IDLE; synchroniser flops = 1.
- rx_i passes a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Tick counter width $clog2(OVERSAMPLE); advances only on baud_tick_i.
- FSM: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: when rx_en_i=1 and rx_s=0, go to START and clear the tick counter.
  - Latch parity_en_i, parity_odd_i and stop2_i at this point; they stay stable for the frame.
- START: at tick OVERSAMPLE/2-1, sample rx_s.
  - rx_s=1: false start; return to IDLE, no output.
  - rx_s=0: clear counter, go to DATA.
- DATA: sample every OVERSAMPLE ticks (bit centre) and shift in LSB first.
  - After DATA_WIDTH bits, go to PARITY if parity latched, else STOP1.
- PARITY: sample p.
  - Error when (^data ^ p) != parity_odd.
- STOP1: sample.
  - 0 sets the framing error.
  - Go to STOP2 if stop2 latched, else complete the frame.
- STOP2: sample; 0 also sets the framing error.
- Frame completion: in the clk cycle after the final stop-bit sample tick, load data and flags into the holding register.
  - Then go to IDLE if rx_s=1, else WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a held-low line from retriggering.
- Break: data all zero, stop bit low and (parity bit low or parity disabled). Sets break_o and framing_err_o together.
- Handshake:
  - rx_valid_o stays high until the cycle where rx_valid_o & rx_ready_i.
  - The flags follow the same rule as rx_valid_o.
- Completion while rx_valid_o=1 and rx_ready_i=0:
  - The new frame is discarded; the held word is unchanged.
  - overrun_o pulses for 1 cycle.
- Completion in the same cycle as a transfer: the new word loads, rx_valid_o stays 1, no overrun.
- rx_en_i deasserted mid-frame: abort to IDLE next cycle, no output; the held word is unaffected.
- Reset asserted mid-frame: immediate return to reset state, held word lost.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every bit (start, data, parity, stop) is the 2-of-3 majority of rx_s at ticks OVERSAMPLE/2-2, -1 and 0 relative to centre.
  - The start-bit false-start check uses the majority value.
- Undefined: single sample at the centre tick; the vote logic is removed.

Test Plan:
- DATA_WIDTH=8, OVERSAMPLE=16, no parity, 1 stop: send 0xA5.
  - rx_data_o=0xA5, rx_valid_o=1 one clk after the stop-centre tick, all error flags 0.
- Odd parity: send 0x3C with parity bit 0 (correct is 1).
  - rx_data_o=0x3C, parity_err_o=1.
  - Resend with bit 1: parity_err_o=0.
- stop2_i=1: send 0x5A with second stop bit low.
  - framing_err_o=1, break_o=0.
  - Then hold rx low 0x00 frame: break_o=1, framing_err_o=1; FSM stays WAIT_HIGH until rx returns high.
- Glitch: rx low for 4 ticks then high.
  - No rx_valid_o; busy_o falls back to 0 after the START check.
- Overrun: rx_ready_i=0, send 0x11 then 0x22.
  - Held word stays 0x11, overrun_o pulses once.
  - Repeat with rx_ready_i=1 at the second completion cycle: 0x22 loads, no overrun.
- Reset and disable mid-frame:
  - rst_ni low during DATA bit 3: all outputs 0 immediately.
  - rx_en_i low mid-frame: no output; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: oversampled bit recovery, parity/stop checking, valid/ready holding register.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  baud_tick_i,
  input  logic                  rx_i,
  input  logic                  rx_en_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic                  parity_err_o,
  output logic                  framing_err_o,
  output logic                  break_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
  } state_e;

  state_e                state_q, state_d;
  logic                  rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d, par_odd_q, par_odd_d, stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d, pe_frm_q, pe_frm_d, fe_frm_q, fe_frm_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
  logic                  overrun_q, overrun_d, busy_q, busy_d;
  logic                  bit_c, sample_tick_c, done_c, stop_low_c;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  // hist_q holds rx_s from the two ticks preceding the current one
  always_comb begin
    hist_d = hist_q;
    if (baud_tick_i) hist_d = {hist_q[0], rx_s_q};
    bit_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
  end
`else
  always_comb bit_c = rx_s_q;
`endif

  always_comb begin
    sample_tick_c = baud_tick_i &&
                    (cnt_q == ((state_q == S_START) ? HALF_LAST : FULL_LAST));
  end

  // Next-state, datapath and holding register update
  always_comb begin
    state_d    = state_q;
    rx_meta_d  = rx_i;
    rx_s_d     = rx_meta_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    pe_frm_d   = pe_frm_q;
    fe_frm_d   = fe_frm_q;
    hold_d     = hold_q;
    valid_d    = valid_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    brk_d      = brk_q;
    overrun_d  = 1'b0;
    done_c     = 1'b0;
    stop_low_c = 1'b0;

    if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      brk_d   = 1'b0;
    end

    if (state_q != S_IDLE && state_q != S_WAIT_HIGH && baud_tick_i) begin
      cnt_d = sample_tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    if (!rx_en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_START;
            par_en_d  = parity_en_i;
            par_odd_d = parity_odd_i;
            stop2_d   = stop2_i;
            par_bit_d = 1'b0;
            pe_frm_d  = 1'b0;
            fe_frm_d  = 1'b0;
          end
        end
        S_START: begin
          if (sample_tick_c) begin
            state_d   = bit_c ? S_IDLE : S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          if (sample_tick_c) begin
            shift_d   = {bit_c, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? S_PARITY : S_STOP1;
          end
        end
        S_PARITY: begin
          if (sample_tick_c) begin
            par_bit_d = bit_c;
            pe_frm_d  = ((^shift_q) ^ bit_c) != par_odd_q;
            state_d   = S_STOP1;
          end
        end
        S_STOP1: begin
          if (sample_tick_c) begin
            if (stop2_q) begin
              fe_frm_d = !bit_c;
              state_d  = S_STOP2;
            end else begin
              done_c     = 1'b1;
              stop_low_c = !bit_c;
            end
          end
        end
        S_STOP2: begin
          if (sample_tick_c) begin
            done_c     = 1'b1;
            stop_low_c = fe_frm_q | !bit_c;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // A finished frame only lands if the holding register is free this cycle
    if (done_c) begin
      state_d = rx_s_q ? S_IDLE : S_WAIT_HIGH;
      if (!valid_q || rx_ready_i) begin
        hold_d  = shift_q;
        valid_d = 1'b1;
        pe_d    = par_en_q & pe_frm_q;
        fe_d    = stop_low_c;
        brk_d   = (shift_q == '0) && stop_low_c && (!par_en_q || !par_bit_q);
      end else begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      pe_frm_q  <= 1'b0;
      fe_frm_q  <= 1'b0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      brk_q     <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      hist_q    <= 2'b11;
`endif
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      pe_frm_q  <= pe_frm_d;
      fe_frm_q  <= fe_frm_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      brk_q     <= brk_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
`ifdef UART_RX_MAJORITY_EN
      hist_q    <= hist_d;
`endif
    end
  end

  assign rx_data_o     = hold_q;
  assign rx_valid_o    = valid_q;
  assign parity_err_o  = pe_q;
  assign framing_err_o = fe_q;
  assign break_o       = brk_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: 8 data bits, x16 oversampling, baud tick every second clock.
module tb_uart_rx_core;

  localparam int BIT_CLKS = 32;

  logic       clk_i, rst_ni, baud_tick_i, rx_i, rx_en_i;
  logic       parity_en_i, parity_odd_i, stop2_i, rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, parity_err_o, framing_err_o, break_o, overrun_o, busy_o;

  int  total = 0;
  int  bad = 0;
  int  ov_cnt = 0;
  int  ov0;
  time rise_t = 0;
  time stop_t;

  uart_rx_core #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .baud_tick_i(baud_tick_i), .rx_i(rx_i),
    .rx_en_i(rx_en_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
    .stop2_i(stop2_i), .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
    .rx_ready_i(rx_ready_i), .parity_err_o(parity_err_o),
    .framing_err_o(framing_err_o), .break_o(break_o), .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    baud_tick_i = 1'b0;
    forever begin
      @(negedge clk_i);
      baud_tick_i = ~baud_tick_i;
    end
  end

  always @(posedge clk_i) if (overrun_o) ov_cnt <= ov_cnt + 1;
  always @(posedge rx_valid_o) rise_t <= $time;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_i = b;
    repeat (BIT_CLKS) @(negedge clk_i);
    #1;
  endtask

  // Start frames 1ns after a negedge at which the tick has just dropped
  task automatic align();
    @(negedge clk_i);
    #1;
    if (baud_tick_i) begin
      @(negedge clk_i);
      #1;
    end
  endtask

  task automatic accept();
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    #1;
    rx_ready_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic s1, input logic two_stop, input logic s2,
                            input logic rdy_at_done, output time last_stop_t);
    logic last;
    align();
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
    if (two_stop) begin
      drive_bit(s1);
      last = s2;
    end else begin
      last = s1;
    end
    last_stop_t = $time;
    if (rdy_at_done) begin
      // ready high across exactly the posedge 174ns into the final stop bit
      rx_i = last;
      #169 rx_ready_i = 1'b1;
      #11 rx_ready_i = 1'b0;
      repeat (14) @(negedge clk_i);
      #1;
    end else begin
      drive_bit(last);
    end
  endtask

  initial begin
    rst_ni = 1'b0; rx_i = 1'b1; rx_en_i = 1'b0; parity_en_i = 1'b0;
    parity_odd_i = 1'b0; stop2_i = 1'b0; rx_ready_i = 1'b0;
    repeat (4) @(negedge clk_i);
    #1;
    check("reset_data", 32'(rx_data_o), 32'h0);
    check("reset_valid", 32'(rx_valid_o), 32'h0);
    check("reset_perr", 32'(parity_err_o), 32'h0);
    check("reset_ferr", 32'(framing_err_o), 32'h0);
    check("reset_break", 32'(break_o), 32'h0);
    check("reset_overrun", 32'(overrun_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    rst_ni = 1'b1;
    rx_en_i = 1'b1;
    repeat (8) @(negedge clk_i);
    #1;

    // 0xA5, no parity, one stop bit
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, stop_t);
    check("a5_valid_latency_ns", 32'(rise_t - stop_t), 32'd174);
    check("a5_data", 32'(rx_data_o), 32'hA5);
    check("a5_valid", 32'(rx_valid_o), 32'h1);
    check("a5_perr", 32'(parity_err_o), 32'h0);
    check("a5_ferr", 32'(framing_err_o), 32'h0);
    check("a5_break", 32'(break_o), 32'h0);
    check("a5_busy", 32'(busy_o), 32'h0);
    accept();
    check("a5_accept_valid", 32'(rx_valid_o), 32'h0);

    // Odd parity: 0x3C has four ones, so a correct parity bit is 1
    parity_en_i = 1'b1;
    parity_odd_i = 1'b1;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, stop_t);
    check("par_bad_data", 32'(rx_data_o), 32'h3C);
    check("par_bad_valid", 32'(rx_valid_o), 32'h1);
    check("par_bad_perr", 32'(parity_err_o), 32'h1);
    check("par_bad_ferr", 32'(framing_err_o), 32'h0);
    accept();
    check("par_accept_perr", 32'(parity_err_o), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, stop_t);
    check("par_ok_valid", 32'(rx_valid_o), 32'h1);
    check("par_ok_perr", 32'(parity_err_o), 32'h0);
    accept();
    parity_en_i = 1'b0;
    parity_odd_i = 1'b0;

    // Two stop bits, second one low
    stop2_i = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, stop_t);
    check("stop2_data", 32'(rx_data_o), 32'h5A);
    check("stop2_ferr", 32'(framing_err_o), 32'h1);
    check("stop2_break", 32'(break_o), 32'h0);
    check("stop2_perr", 32'(parity_err_o), 32'h0);
    check("stop2_wait_high_busy", 32'(busy_o), 32'h1);
    rx_i = 1'b1;
    repeat (6) @(negedge clk_i);
    #1;
    check("stop2_idle_busy", 32'(busy_o), 32'h0);
    accept();

    // Break: line held low through the whole frame and beyond
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, stop_t);
    check("brk_valid", 32'(rx_valid_o), 32'h1);
    check("brk_data", 32'(rx_data_o), 32'h0);
    check("brk_break", 32'(break_o), 32'h1);
    check("brk_ferr", 32'(framing_err_o), 32'h1);
    repeat (3 * BIT_CLKS) @(negedge clk_i);
    #1;
    check("brk_held_low_busy", 32'(busy_o), 32'h1);
    accept();
    repeat (3 * BIT_CLKS) @(negedge clk_i);
    #1;
    check("brk_no_retrigger_valid", 32'(rx_valid_o), 32'h0);
    rx_i = 1'b1;
    repeat (6) @(negedge clk_i);
    #1;
    check("brk_released_busy", 32'(busy_o), 32'h0);
    stop2_i = 1'b0;

    // Glitch: low for four ticks only
    align();
    rx_i = 1'b0;
    repeat (8) @(negedge clk_i);
    #1;
    check("glitch_start_busy", 32'(busy_o), 32'h1);
    rx_i = 1'b1;
    repeat (BIT_CLKS) @(negedge clk_i);
    #1;
    check("glitch_end_busy", 32'(busy_o), 32'h0);
    check("glitch_valid", 32'(rx_valid_o), 32'h0);

    // Overrun: second frame arrives while the first is still held
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, stop_t);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, stop_t);
    check("ovr_data", 32'(rx_data_o), 32'h11);
    check("ovr_valid", 32'(rx_valid_o), 32'h1);
    check("ovr_pulse_cycles", 32'(ov_cnt - ov0), 32'd1);
    ov0 = ov_cnt;
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, stop_t);
    check("xfer_data", 32'(rx_data_o), 32'h22);
    check("xfer_valid", 32'(rx_valid_o), 32'h1);
    check("xfer_no_overrun", 32'(ov_cnt - ov0), 32'd0);

    // Reset during data bit 3 with 0x22 still held
    align();
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_i = 1'b0;
    repeat (16) @(negedge clk_i);
    #1;
    check("rst_mid_pre_busy", 32'(busy_o), 32'h1);
    rst_ni = 1'b0;
    #1;
    check("rst_mid_data", 32'(rx_data_o), 32'h0);
    check("rst_mid_valid", 32'(rx_valid_o), 32'h0);
    check("rst_mid_busy", 32'(busy_o), 32'h0);
    check("rst_mid_flags", 32'({parity_err_o, framing_err_o, break_o, overrun_o}), 32'h0);
    rx_i = 1'b1;
    repeat (4) @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    #1;

    // Disable mid-frame: held word survives, next frame is clean
    send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, stop_t);
    check("en_held_data", 32'(rx_data_o), 32'h33);
    align();
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #1;
    rx_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    check("en_abort_busy", 32'(busy_o), 32'h0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_i = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk_i);
    #1;
    check("en_abort_valid", 32'(rx_valid_o), 32'h1);
    check("en_abort_data", 32'(rx_data_o), 32'h33);
    rx_en_i = 1'b1;
    accept();
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, stop_t);
    check("en_next_data", 32'(rx_data_o), 32'h81);
    check("en_next_valid", 32'(rx_valid_o), 32'h1);
    check("en_next_flags", 32'({parity_err_o, framing_err_o, break_o}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
